// File: rtl/lead_zero_counter.sv
// Serial leading-zero counter for floating-point adder normalisation.
// Produces shift amount/direction in count_shifter encoding plus the normalised mantissa.
module lead_zero_counter (
    input  logic        Clk,
    input  logic        Clear,
    input  logic [24:0] Data,
    input  logic        Load,
    output logic [7:0]  Count,
    output logic        Direction,
    output logic [23:0] Result,
    output logic        Zero,
    output logic        Busy,
    output logic        Valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] sreg_q, sreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  count_q, count_d;
    logic        dir_q, dir_d;
    logic [23:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;

    // Next-state and result computation; results only change on entry to DONE.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        dir_d    = dir_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (Load) begin
                    if (Data[24]) begin
                        count_d  = 8'd1;
                        dir_d    = 1'b0;
                        result_d = Data[24:1];
                        zero_d   = 1'b0;
                        state_d  = DONE;
                    end else if (Data == 25'd0) begin
                        count_d  = 8'd0;
                        dir_d    = 1'b1;
                        result_d = 24'd0;
                        zero_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        sreg_d  = Data[23:0];
                        cnt_d   = 5'd0;
                        state_d = SCAN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                // Data is known non-zero here, so a one reaches bit 23 within 23 shifts.
                if (sreg_q[23]) begin
                    count_d  = {3'b000, cnt_q};
                    dir_d    = 1'b1;
                    result_d = sreg_q;
                    zero_d   = 1'b0;
                    state_d  = DONE;
                end else begin
                    sreg_d = {sreg_q[22:0], 1'b0};
                    cnt_d  = cnt_q + 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            state_q  <= IDLE;
            sreg_q   <= 24'd0;
            cnt_q    <= 5'd0;
            count_q  <= 8'd0;
            dir_q    <= 1'b0;
            result_q <= 24'd0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign Count     = count_q;
    assign Direction = dir_q;
    assign Result    = result_q;
    assign Zero      = zero_q;
    assign Busy      = busy_q;
    assign Valid     = valid_q;

endmodule

// File: tb/tb_lead_zero_counter.sv
// Self-checking bench for lead_zero_counter: directed table, corner sequences
// and random requests checked against an arithmetic reference model.
module tb_lead_zero_counter;

    logic        Clk = 1'b0;
    logic        Clear = 1'b0;
    logic [24:0] Data = 25'd0;
    logic        Load = 1'b0;
    logic [7:0]  Count;
    logic        Direction;
    logic [23:0] Result;
    logic        Zero;
    logic        Busy;
    logic        Valid;

    int total = 0;
    int bad   = 0;

    lead_zero_counter dut (
        .Clk(Clk), .Clear(Clear), .Data(Data), .Load(Load),
        .Count(Count), .Direction(Direction), .Result(Result),
        .Zero(Zero), .Busy(Busy), .Valid(Valid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [24:0] data;
        logic [7:0]  count;
        logic        dir;
        logic [23:0] result;
        logic        zero;
        int          lat;   // negedges after the accepting edge before Valid is seen
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: normalisation rules expressed directly on the value.
    task automatic model(input logic [24:0] d, output vec_t v);
        int lz;
        v.data = d;
        if (d[24]) begin
            v.count = 8'd1; v.dir = 1'b0; v.result = d[24:1]; v.zero = 1'b0; v.lat = 0;
        end else if (d == 25'd0) begin
            v.count = 8'd0; v.dir = 1'b1; v.result = 24'd0; v.zero = 1'b1; v.lat = 0;
        end else begin
            lz = 0;
            while (d[23 - lz] == 1'b0) lz++;
            v.count = 8'(lz); v.dir = 1'b1; v.result = 24'(d[23:0] << lz);
            v.zero = 1'b0; v.lat = lz + 1;
        end
    endtask

    function automatic logic [23:0] shifter(input logic [23:0] m, input logic [7:0] c, input logic dir);
        if (dir) return m << c;
        else     return m >> c;
    endfunction

    // Issue one request from a negedge and check latency, Busy and results.
    task automatic do_req(input vec_t v, input string nm);
        int  k;
        bit  seen;
        Load = 1'b1;
        Data = v.data;
        @(posedge Clk);
        @(negedge Clk);
        Load = 1'b0;
        Data = 25'($urandom);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            if (Valid) begin
                seen = 1'b1;
            end else begin
                check({nm, "_busy"}, {31'd0, Busy}, 32'd1);
                @(negedge Clk);
                k++;
            end
        end
        check({nm, "_valid_seen"}, {31'd0, seen}, 32'd1);
        check({nm, "_latency"}, k, v.lat);
        check({nm, "_count"}, {24'd0, Count}, {24'd0, v.count});
        check({nm, "_dir"}, {31'd0, Direction}, {31'd0, v.dir});
        check({nm, "_result"}, {8'd0, Result}, {8'd0, v.result});
        check({nm, "_zero"}, {31'd0, Zero}, {31'd0, v.zero});
        check({nm, "_busy_done"}, {31'd0, Busy}, 32'd1);
        @(negedge Clk);
        check({nm, "_valid_pulse"}, {31'd0, Valid}, 32'd0);
        check({nm, "_busy_idle"}, {31'd0, Busy}, 32'd0);
        check({nm, "_hold_result"}, {8'd0, Result}, {8'd0, v.result});
    endtask

    vec_t tbl [6];
    vec_t v;

    initial begin
        tbl[0] = '{25'h00F0FFE, 8'd4,  1'b1, 24'hF0FFE0, 1'b0, 5};
        tbl[1] = '{25'h1A15FC2, 8'd1,  1'b0, 24'hD0AFE1, 1'b0, 0};
        tbl[2] = '{25'h0800000, 8'd0,  1'b1, 24'h800000, 1'b0, 1};
        tbl[3] = '{25'h0000001, 8'd23, 1'b1, 24'h800000, 1'b0, 24};
        tbl[4] = '{25'h0000000, 8'd0,  1'b1, 24'h000000, 1'b1, 0};
        tbl[5] = '{25'h1FFFFFF, 8'd1,  1'b0, 24'hFFFFFF, 1'b0, 0};

        // Reset with Load asserted: Clear wins, nothing starts.
        @(negedge Clk);
        Clear = 1'b1; Load = 1'b1; Data = 25'h1FFFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check("rst_outputs", {Count, Direction, Result}, 32'd0);
            check("rst_flags", {29'd0, Zero, Busy, Valid}, 32'd0);
        end
        Clear = 1'b0; Load = 1'b0; Data = 25'd0;
        @(negedge Clk);
        check("rst_after_busy", {31'd0, Busy}, 32'd0);

        for (int i = 0; i < 6; i++) do_req(tbl[i], $sformatf("tbl%0d", i));

        // Chained into a count_shifter model.
        do_req(tbl[0], "chain");
        check("chain_shifter", {8'd0, shifter(24'h0F0FFE, Count, Direction)}, {8'd0, 24'hF0FFE0});
        check("chain_match", {8'd0, shifter(24'h0F0FFE, Count, Direction)}, {8'd0, Result});

        // Abort: Clear at E5 of a long scan, no Valid afterwards.
        Load = 1'b1; Data = 25'h0000001;
        @(posedge Clk);
        @(negedge Clk);
        Load = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge Clk);
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        check("abort_outputs", {Count, Direction, Result}, 32'd0);
        check("abort_flags", {29'd0, Zero, Busy, Valid}, 32'd0);
        begin
            bit any_valid;
            any_valid = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge Clk);
                if (Valid || Busy) any_valid = 1'b1;
            end
            check("abort_no_valid", {31'd0, any_valid}, 32'd0);
        end

        // Busy-ignore: a carry request during SCAN must not be taken.
        begin
            int k;
            int nvalid;
            Load = 1'b1; Data = 25'h0000001;
            @(posedge Clk);
            @(negedge Clk);
            Data = 25'h1000000;
            for (int i = 0; i < 6; i++) @(negedge Clk);
            Load = 1'b0;
            k = 0; nvalid = 0;
            while (!Valid && k < 40) begin @(negedge Clk); k++; end
            check("ignore_count", {24'd0, Count}, 32'd23);
            check("ignore_dir", {31'd0, Direction}, 32'd1);
            for (int i = 0; i < 10; i++) begin
                @(negedge Clk);
                if (Valid) nvalid++;
            end
            check("ignore_no_second", nvalid, 0);
            check("ignore_hold_count", {24'd0, Count}, 32'd23);
        end

        // Random requests against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic [24:0] d;
            int mode;
            mode = $urandom_range(0, 9);
            if (mode == 0)      d = 25'd0;
            else if (mode <= 2) d = {1'b1, 24'($urandom)};
            else begin
                d = {1'b0, 24'($urandom)} >> $urandom_range(0, 23);
                if (d == 25'd0) d = 25'd1;
            end
            model(d, v);
            do_req(v, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
